alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
// Parametrised sequential ALU; next generation of the combinational 4-op ALU.
// Registered result and flags, valid/ready handshakes on both sides, 8 ops
// including multi-cycle shifts and an optional shift-add multiplier.
// Sits between decode/operand fetch and writeback in the GPP datapath.
// PARAMETERS
// WIDTH   8  operand/result width in bits; legal range WIDTH >= 2
// SHW     $clog2(WIDTH)  localparam: width of shift-amount field taken from src_b
// PORTS
// clk            in   1      clock; all state changes on rising edge
// reset_n        in   1      asynchronous, active-low reset
// in_valid       in   1      operands and op are valid this cycle
// in_ready       out  1      block can accept an operation this cycle
// op             in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
// src_a          in   WIDTH  operand A
// src_b          in   WIDTH  operand B; shift amount = src_b[SHW-1:0]
// out_valid      out  1      ALU_out and flags hold a completed result
// out_ready      in   1      consumer accepts the result this cycle
// ALU_out        out  WIDTH  registered result
// zero_flag      out  1      ALU_out == 0
// carry_flag     out  1      carry/borrow/shift-out/mul-overflow (see below)
// sign_flag      out  1      ALU_out[WIDTH-1]
// overflow_flag  out  1      two's-complement overflow
// BEHAVIOUR
// - Reset: state IDLE, out_valid=0, ALU_out=0, all flags 0, counter 0; reset mid-op aborts it, result discarded.
// - FSM IDLE -> (accept & multi-cycle op & count>0) EXEC -> DONE; IDLE -> (accept, 1-cycle op) DONE.
// - DONE -> IDLE on out_ready with no new accept; DONE -> EXEC/DONE on out_ready with new accept.
// - in_ready = (state==IDLE) | (state==DONE & out_ready); accept = in_valid & in_ready.
// - Operands and op are captured on accept; inputs are ignored at all other times.
// - out_valid = (state==DONE); ALU_out and flags are stable while out_valid=1 and out_ready=0.
// - Latency accept->out_valid: 1 cycle for ADD/SUB/AND/OR/XOR and shifts with amount 0.
// - Shifts with amount n>0: n+1 cycles (one bit per EXEC cycle). MUL: WIDTH+1 cycles.
// - ADD: carry = bit WIDTH of the (WIDTH+1)-bit zero-extended sum; overflow = operands same sign, result differs.
// - SUB: carry = borrow (1 when src_a < src_b unsigned); overflow = operand signs differ and result sign != src_a sign.
// - AND/OR/XOR: carry=0, overflow=0. No X is ever driven.
// - SHL/SHR: logical, zero fill. carry = last bit shifted out (0 when amount=0); overflow=0.
// - MUL: unsigned, ALU_out = low WIDTH bits; carry = overflow = (high WIDTH bits != 0).
// - zero/sign are always derived from the final ALU_out for every op.
// - Back-to-back: a result consumed in the same cycle a new op is accepted gives no bubble for 1-cycle ops.
// CONFIGURATION
// ALU_MUL_EN defined: op 111 runs the shift-add multiplier described above.
// ALU_MUL_EN undefined: no multiplier logic; op 111 completes in 1 cycle with ALU_out=0,
//   zero=1, carry=0, sign=0, overflow=0.
// TESTING (WIDTH=8)
// - Reset held low mid-MUL, then released -> out_valid=0, ALU_out=0, flags 0, in_ready=1.
// - ADD 0x7F+0x01 -> 0x80, Z0 C0 S1 V1 one cycle after accept; ADD 0xFF+0x01 -> 0x00, Z1 C1 S0 V0.
// - SUB 0x03-0x05 -> 0xFE, C1 S1 V0 Z0; SUB 0x80-0x01 -> 0x7F, V1 C0.
// - SHL 0x81 by 3 -> out_valid 4 cycles after accept, 0x08, C0; SHR 0x05 by 1 -> 0x02, C1; amount 0 -> 1 cycle, C0.
// - MUL 0x10*0x11 (ALU_MUL_EN) -> 0x10, C1 V1 after 9 cycles; 0x03*0x04 -> 0x0C, C0; without macro -> 0x00, Z1.
// - out_ready held low 5 cycles -> ALU_out/flags stable, in_ready=0; release with in_valid=1 -> new op accepted same cycle.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: sequential ALU with registered result/flags and valid/ready
// handshakes on both sides. One-cycle ADD/SUB/AND/OR/XOR, bit-serial logical
// shifts (one bit per cycle) and an optional shift-add multiplier.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> op 111 runs a WIDTH-step shift-add unsigned multiplier
//   undefined -> no multiplier logic; op 111 completes in one cycle with a
//                zero result (zero flag set, all other flags clear)

module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag
);

    // Shift amount comes from the low SHW bits of src_b. The step counter gets
    // one extra bit so it can also hold WIDTH for the multiplier.
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t           state_q, state_d;
    logic [2:0]       opCode_q, opCode_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mulHi_q, mulHi_d;
    logic [WIDTH-1:0] mulCand_q, mulCand_d;
`endif

    logic             accept;
    logic             isShift;
    logic             mulOp;
    logic             startMulti;
    logic             lastStep;
    logic [SHW-1:0]   shiftAmount;

    assign shiftAmount = src_b[SHW-1:0];
    assign isShift     = (op == OP_SHL) || (op == OP_SHR);
`ifdef ALU_MUL_EN
    assign mulOp       = (op == OP_MUL);
`else
    assign mulOp       = 1'b0;
`endif
    // Zero-amount shifts finish in one cycle like the plain logic ops.
    assign startMulti  = (isShift && (shiftAmount != '0)) || mulOp;
    assign lastStep    = (count_q == CW'(1));
    assign accept      = in_valid && in_ready;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a result consumed in the same cycle a new op arrives
    // goes straight to the next op without passing through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = startMulti ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (lastStep) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = startMulti ? EXEC : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: operand capture on accept, one shift/multiply step
    // per EXEC cycle, and result/flag update whenever an op completes.
    always_comb begin
        logic [WIDTH:0]   wide;
        logic             writeRes;
        logic [WIDTH-1:0] newRes;
        logic             newCarry;
        logic             newOvf;
        logic             stepOut;
`ifdef ALU_MUL_EN
        logic [WIDTH:0]   mulSum;
        logic [WIDTH:0]   mulAddend;
`endif

        opCode_d  = opCode_q;
        work_d    = work_q;
        count_d   = count_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
`ifdef ALU_MUL_EN
        mulHi_d   = mulHi_q;
        mulCand_d = mulCand_q;
        mulSum    = '0;
        mulAddend = '0;
`endif
        wide      = '0;
        writeRes  = 1'b0;
        newRes    = '0;
        newCarry  = 1'b0;
        newOvf    = 1'b0;
        stepOut   = 1'b0;

        if (accept) begin
            opCode_d = op;
            case (op)
                OP_ADD: begin
                    wide     = {1'b0, src_a} + {1'b0, src_b};
                    writeRes = 1'b1;
                    newRes   = wide[WIDTH-1:0];
                    newCarry = wide[WIDTH];
                    newOvf   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                               (newRes[WIDTH-1] != src_a[WIDTH-1]);
                end
                OP_SUB: begin
                    // Top bit of the zero-extended difference is the borrow.
                    wide     = {1'b0, src_a} - {1'b0, src_b};
                    writeRes = 1'b1;
                    newRes   = wide[WIDTH-1:0];
                    newCarry = wide[WIDTH];
                    newOvf   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                               (newRes[WIDTH-1] != src_a[WIDTH-1]);
                end
                OP_AND: begin
                    writeRes = 1'b1;
                    newRes   = src_a & src_b;
                end
                OP_OR: begin
                    writeRes = 1'b1;
                    newRes   = src_a | src_b;
                end
                OP_XOR: begin
                    writeRes = 1'b1;
                    newRes   = src_a ^ src_b;
                end
                OP_SHL, OP_SHR: begin
                    if (shiftAmount == '0) begin
                        writeRes = 1'b1;
                        newRes   = src_a;
                    end else begin
                        work_d  = src_a;
                        count_d = {1'b0, shiftAmount};
                    end
                end
                OP_MUL: begin
`ifdef ALU_MUL_EN
                    mulHi_d   = '0;
                    mulCand_d = src_a;
                    work_d    = src_b;
                    count_d   = CW'(WIDTH);
`else
                    writeRes = 1'b1;
                    newRes   = '0;
`endif
                end
                default: begin
                    writeRes = 1'b1;
                    newRes   = '0;
                end
            endcase
        end else if (state_q == EXEC) begin
            count_d = count_q - CW'(1);
            case (opCode_q)
                OP_SHL: begin
                    stepOut = work_q[WIDTH-1];
                    work_d  = work_q << 1;
                    if (lastStep) begin
                        writeRes = 1'b1;
                        newRes   = work_d;
                        newCarry = stepOut;
                    end
                end
                OP_SHR: begin
                    stepOut = work_q[0];
                    work_d  = work_q >> 1;
                    if (lastStep) begin
                        writeRes = 1'b1;
                        newRes   = work_d;
                        newCarry = stepOut;
                    end
                end
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    // {mulHi, work} holds the partial product in its upper
                    // half and the unconsumed multiplier bits in its lower half.
                    mulAddend = work_q[0] ? {1'b0, mulCand_q} : '0;
                    mulSum    = {1'b0, mulHi_q} + mulAddend;
                    mulHi_d   = mulSum[WIDTH:1];
                    work_d    = {mulSum[0], work_q[WIDTH-1:1]};
                    if (lastStep) begin
                        writeRes = 1'b1;
                        newRes   = work_d;
                        newCarry = (mulHi_d != '0);
                        newOvf   = (mulHi_d != '0);
                    end
                end
`endif
                default: begin
                    writeRes = 1'b1;
                    newRes   = '0;
                end
            endcase
        end

        if (writeRes) begin
            result_d = newRes;
            zero_d   = (newRes == '0);
            sign_d   = newRes[WIDTH-1];
            carry_d  = newCarry;
            ovf_d    = newOvf;
        end
    end

    // Datapath registers; everything clears on reset so no flag starts set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opCode_q  <= '0;
            work_q    <= '0;
            count_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ALU_MUL_EN
            mulHi_q   <= '0;
            mulCand_q <= '0;
`endif
        end else begin
            opCode_q  <= opCode_d;
            work_q    <= work_d;
            count_q   <= count_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
`ifdef ALU_MUL_EN
            mulHi_q   <= mulHi_d;
            mulCand_q <= mulCand_d;
`endif
        end
    end

    assign ALU_out       = result_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign sign_flag     = sign_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle at WIDTH=8.
// Inputs change 1 time unit after the falling edge; all sampling happens
// 1 time unit before the rising edge.

module tb_alu_multicycle;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALU_out;
    logic       zero_flag;
    logic       carry_flag;
    logic       sign_flag;
    logic       overflow_flag;

    typedef struct {
        logic [2:0] op;
        logic [7:0] res;
        logic       c;
        logic       v;
        int         lat;
        int         acceptCycle;
        bit         chkLat;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   failCount  = 0;
    int   cycle      = 0;

    alu_multicycle #(.WIDTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .src_a         (src_a),
        .src_b         (src_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_out       (ALU_out),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .sign_flag     (sign_flag),
        .overflow_flag (overflow_flag)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure accept-to-output latency.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model of one operation at WIDTH=8.
    function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic v, output int lat);
        int s;
        int sa;
        int sb;
        int n;
        sa  = $signed(a);
        sb  = $signed(b);
        n   = int'(b) % 8;
        r   = 8'h00;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        case (o)
            3'd0: begin
                s = int'(a) + int'(b);
                r = s[7:0];
                c = (s > 255);
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            3'd1: begin
                s = int'(a) - int'(b);
                r = s[7:0];
                c = (a < b);
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r   = a << n;
                c   = (n == 0) ? 1'b0 : a[8-n];
                lat = (n == 0) ? 1 : n + 1;
            end
            3'd6: begin
                r   = a >> n;
                c   = (n == 0) ? 1'b0 : a[n-1];
                lat = (n == 0) ? 1 : n + 1;
            end
            default: begin
`ifdef ALU_MUL_EN
                s   = int'(a) * int'(b);
                r   = s[7:0];
                c   = (s > 255);
                v   = (s > 255);
                lat = 9;
`else
                r   = 8'h00;
`endif
            end
        endcase
    endfunction

    // Present one op and hold it until accepted; the expected result is
    // queued at the sampling point right before the accepting edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input bit chkLat, output int waited);
        exp_t e;
        op       = o;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        waited   = 0;
        while (1) begin
            #3;
            if (in_ready) begin
                model(o, a, b, e.res, e.c, e.v, e.lat);
                e.op          = o;
                e.acceptCycle = cycle;
                e.chkLat      = chkLat;
                expQ.push_back(e);
                break;
            end
            waited++;
            if (waited >= 60) begin
                checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
        @(negedge clk);
        #1;
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_out_valid"}, {31'd0, out_valid}, 0);
        checkOutput({pfx, "_in_ready"},  {31'd0, in_ready}, 1);
        checkOutput({pfx, "_alu_out"},   {24'd0, ALU_out}, 0);
        checkOutput({pfx, "_flags"},
                    {28'd0, zero_flag, carry_flag, sign_flag, overflow_flag}, 0);
    endtask

    // Scoreboard consumer: compares every result taken by the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (reset_n && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out", {31'd0, out_valid}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("op%0d_res", e.op),   {24'd0, ALU_out}, {24'd0, e.res});
                    checkOutput($sformatf("op%0d_zero", e.op),  {31'd0, zero_flag}, {31'd0, (e.res == 8'h00)});
                    checkOutput($sformatf("op%0d_sign", e.op),  {31'd0, sign_flag}, {31'd0, e.res[7]});
                    checkOutput($sformatf("op%0d_carry", e.op), {31'd0, carry_flag}, {31'd0, e.c});
                    checkOutput($sformatf("op%0d_ovf", e.op),   {31'd0, overflow_flag}, {31'd0, e.v});
                    if (e.chkLat)
                        checkOutput($sformatf("op%0d_latency", e.op), cycle - e.acceptCycle, e.lat);
                end
            end
        end
    end

    logic [2:0] tOp [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                             3'd5, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7, 3'd0};
    logic [7:0] tA  [14] = '{8'h7F, 8'hFF, 8'h03, 8'h80, 8'hF0, 8'h0F, 8'hAA,
                             8'h81, 8'h05, 8'hA5, 8'h80, 8'h10, 8'h03, 8'h00};
    logic [7:0] tB  [14] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h3C, 8'h30, 8'hAA,
                             8'h03, 8'h01, 8'h08, 8'h07, 8'h11, 8'h04, 8'h00};

    // Main stimulus sequence.
    initial begin
        int w;
        int k;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'd0;
        src_a     = 8'h00;
        src_b     = 8'h00;

        repeat (2) @(negedge clk);
        #4;
        checkResetState("reset");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;

        // Directed cases, each drained so latency is measured from idle.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tOp[i], tA[i], tB[i], 1'b1, w);
            waitDrain();
        end

        // Back-to-back single-cycle ops must be accepted with no bubble.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'(i % 5), 8'(8'h31 * i + 8'h17), 8'(8'h5B * i + 8'h09), 1'b1, w);
            checkOutput("b2b_wait", w, 0);
        end
        waitDrain();

        // Consumer stall: output held, new ops refused, then released with a
        // new op accepted in the same cycle.
        out_ready = 1'b0;
        applyStimulus(3'd0, 8'h12, 8'h34, 1'b0, w);
        in_valid = 1'b1;
        op       = 3'd1;
        src_a    = 8'hFF;
        src_b    = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #3;
            checkOutput("stall_valid",   {31'd0, out_valid}, 1);
            checkOutput("stall_inready", {31'd0, in_ready}, 0);
            checkOutput("stall_res",     {24'd0, ALU_out}, 32'h46);
            checkOutput("stall_flags",
                        {28'd0, zero_flag, carry_flag, sign_flag, overflow_flag}, 0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(3'd4, 8'h3C, 8'hFF, 1'b1, w);
        checkOutput("release_wait", w, 0);
        waitDrain();

        // Random mix with idle gaps.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1, w);
            k = $urandom_range(0, 2);
            if (k > 0) begin
                repeat (k) @(negedge clk);
                #1;
            end
        end
        waitDrain();

        // Reset while a MUL is in flight discards it.
        out_ready = 1'b0;
        applyStimulus(3'd7, 8'h10, 8'h11, 1'b0, w);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        expQ.delete();
        reset_n = 1'b1;
        #3;
        checkResetState("midop_reset");
        @(negedge clk);
        #1;
        out_ready = 1'b1;

        applyStimulus(3'd0, 8'hFF, 8'h01, 1'b1, w);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
